// File: rtl/delay_pkg.sv
// Shared definitions for the DELAY timer and its receive-side period checker.
package delay_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEFAULT_N     = 200000;
    localparam int DEFAULT_CBITS = 18;

    // The generator emits one tick every N+1 cycles.
    function automatic int period_of(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/delay_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an increment yields 1.
module delay_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && count != MAX) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/delay_period_checker.sv
// Liveness/timing monitor for the DELAY tick: measures pulse spacing, flags early/late pulses, declares lock.
module delay_period_checker
    import delay_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int CBITS    = DEFAULT_CBITS,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int ECNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig,
    input  logic              err_clr,
    output logic              locked,
    output logic              in_window,
    output logic              early_err,
    output logic              late_err,
    output logic [CBITS-1:0]  period,
    output logic [ECNT_W-1:0] err_cnt
);

    localparam int P     = period_of(N);
    // A tolerance reaching P leaves no early region at all.
    localparam int LO    = (TOL >= P) ? 0 : P - TOL;
    localparam int HI    = P + TOL;
    localparam int GBITS = $clog2(LOCK_CNT + 1);

    localparam logic [CBITS-1:0] LO_C    = CBITS'(LO);
    localparam logic [CBITS-1:0] HI_C    = CBITS'(HI);
    localparam logic [CBITS-1:0] CNT_MAX = '1;
    localparam logic [GBITS-1:0] LOCK_C  = GBITS'(LOCK_CNT);

    state_t             state, state_next;
    logic [CBITS-1:0]   cnt, cnt_next;
    logic [GBITS-1:0]   good, good_next, good_inc;
    logic [CBITS-1:0]   period_next;
    logic               early_next, late_next, win_next;
    logic               is_good, is_early, is_late;

    always_comb begin
        cnt_next = sig ? CBITS'(1) : ((cnt == CNT_MAX) ? cnt : cnt + CBITS'(1));
        is_early = sig && (cnt < LO_C);
        is_good  = sig && (cnt >= LO_C) && (cnt <= HI_C);
        is_late  = !sig && (cnt == HI_C);
        good_inc = good + GBITS'(1);
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        good_next   = good;
        period_next = period;
        early_next  = 1'b0;
        late_next   = 1'b0;

        unique case (state)
            HUNT: begin
                if (sig) begin
                    state_next = TRACK;
                    good_next  = '0;
                end
            end
            TRACK: begin
                if (is_good) begin
                    period_next = cnt;
                    if (good_inc == LOCK_C) begin
                        state_next = LOCKED;
                        good_next  = '0;
                    end else begin
                        good_next = good_inc;
                    end
                end else if (is_early) begin
                    early_next  = 1'b1;
                    period_next = cnt;
                    good_next   = '0;
                end else if (is_late) begin
                    late_next  = 1'b1;
                    good_next  = '0;
                    state_next = HUNT;
                end
            end
            LOCKED: begin
                if (is_good) begin
                    period_next = cnt;
                end else if (is_early) begin
                    early_next  = 1'b1;
                    period_next = cnt;
                    good_next   = '0;
                    state_next  = TRACK;
                end else if (is_late) begin
                    late_next  = 1'b1;
                    good_next  = '0;
                    state_next = HUNT;
                end
            end
            default: begin
                state_next = HUNT;
                good_next  = '0;
            end
        endcase

        // Window flag describes the counter value that will be visible next cycle.
        win_next = (state_next != HUNT) && (cnt_next >= LO_C) && (cnt_next <= HI_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            cnt       <= '0;
            good      <= '0;
            period    <= '0;
            locked    <= 1'b0;
            in_window <= 1'b0;
            early_err <= 1'b0;
            late_err  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            good      <= good_next;
            period    <= period_next;
            locked    <= (state_next == LOCKED);
            in_window <= win_next;
            early_err <= early_next;
            late_err  <= late_next;
        end
    end

    delay_sat_cnt #(
        .WIDTH (ECNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (early_next | late_next),
        .clr   (err_clr),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_delay_period_checker.sv
// Directed bench for delay_period_checker with N=8 (P=9), TOL=1, LOCK_CNT=3, ECNT_W=2.
module tb_delay_period_checker;

    localparam int N        = 8;
    localparam int CBITS    = 5;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 3;
    localparam int ECNT_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sig = 1'b0;
    logic              err_clr = 1'b0;
    logic              locked;
    logic              in_window;
    logic              early_err;
    logic              late_err;
    logic [CBITS-1:0]  period;
    logic [ECNT_W-1:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int cur_cnt = 0;

    delay_period_checker #(
        .N        (N),
        .CBITS    (CBITS),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT),
        .ECNT_W   (ECNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig       (sig),
        .err_clr   (err_clr),
        .locked    (locked),
        .in_window (in_window),
        .early_err (early_err),
        .late_err  (late_err),
        .period    (period),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sig = 1'b0;
            step();
            cur_cnt++;
        end
    endtask

    // Zeros until the model spacing reaches sp, then one high cycle; window and error pulses watched throughout.
    task automatic pulse(input int sp);
        int win_bad = 0;
        int err_bad = 0;
        while (cur_cnt < sp) begin
            sig = 1'b0;
            step();
            cur_cnt++;
            if (in_window !== ((cur_cnt >= 8) && (cur_cnt <= 10))) win_bad++;
            if (early_err !== 1'b0 || late_err !== 1'b0) err_bad++;
        end
        sig = 1'b1;
        step();
        sig = 1'b0;
        cur_cnt = 1;
        checks++;
        if (win_bad != 0) begin
            errors++;
            $display("FAIL pulse_window sp=%0d: %0d wrong cycles, required 0", sp, win_bad);
        end
        checks++;
        if (err_bad != 0) begin
            errors++;
            $display("FAIL pulse_quiet sp=%0d: %0d error pulses between ticks, required 0", sp, err_bad);
        end
    endtask

    task automatic sync_pulse();
        sig = 1'b1;
        step();
        sig = 1'b0;
        cur_cnt = 1;
        checks++;
        if (locked !== 1'b0 || early_err !== 1'b0 || late_err !== 1'b0) begin
            errors++;
            $display("FAIL sync: locked/early/late=%b%b%b required 000", locked, early_err, late_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sig = 1'b0;
        err_clr = 1'b0;
        step();
        step();
        checks++;
        if ({locked, in_window, early_err, late_err, period, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: l=%b w=%b e=%b t=%b p=%0d c=%0d required all 0",
                     locked, in_window, early_err, late_err, period, err_cnt);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cur_cnt = 1;
    endtask

    task automatic test_lock();
        idle(3);
        sync_pulse();
        pulse(9);
        checks++;
        if (locked !== 1'b0 || period !== 5'd9) begin
            errors++;
            $display("FAIL lock_p2: locked=%b period=%0d required 0/9", locked, period);
        end
        pulse(9);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_p3: locked=%b required 0", locked);
        end
        pulse(9);
        checks++;
        if (locked !== 1'b1 || period !== 5'd9 || err_cnt !== 2'd0 || in_window !== 1'b0) begin
            errors++;
            $display("FAIL lock_p4: locked=%b period=%0d err_cnt=%0d win=%b required 1/9/0/0",
                     locked, period, err_cnt, in_window);
        end
    endtask

    task automatic test_early();
        pulse(6);
        checks++;
        if (early_err !== 1'b1 || locked !== 1'b0 || period !== 5'd6 || err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL early: early=%b locked=%b period=%0d err_cnt=%0d required 1/0/6/1",
                     early_err, locked, period, err_cnt);
        end
        pulse(9);
        checks++;
        if (early_err !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL early_relock1: early=%b locked=%b required 0/0", early_err, locked);
        end
        pulse(9);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL early_relock2: locked=%b required 0", locked);
        end
        pulse(9);
        checks++;
        if (locked !== 1'b1 || period !== 5'd9) begin
            errors++;
            $display("FAIL early_relock3: locked=%b period=%0d required 1/9", locked, period);
        end
    endtask

    task automatic test_late();
        int late_seen = 0;
        int win_seen = 0;
        idle(10 - cur_cnt);
        checks++;
        if (late_err !== 1'b0 || in_window !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL late_edge: late=%b win=%b locked=%b at cnt 10 required 0/1/1",
                     late_err, in_window, locked);
        end
        idle(1);
        checks++;
        if (late_err !== 1'b1 || locked !== 1'b0 || in_window !== 1'b0 || err_cnt !== 2'd2) begin
            errors++;
            $display("FAIL late_fire: late=%b locked=%b win=%b err_cnt=%0d required 1/0/0/2",
                     late_err, locked, in_window, err_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (late_err !== 1'b0) late_seen++;
            if (in_window !== 1'b0) win_seen++;
        end
        checks++;
        if (late_seen != 0 || win_seen != 0 || err_cnt !== 2'd2) begin
            errors++;
            $display("FAIL late_hunt: late cycles=%0d win cycles=%0d err_cnt=%0d required 0/0/2",
                     late_seen, win_seen, err_cnt);
        end
    endtask

    task automatic test_window();
        sync_pulse();
        pulse(8);
        checks++;
        if (period !== 5'd8 || locked !== 1'b0 || early_err !== 1'b0) begin
            errors++;
            $display("FAIL win_8: period=%0d locked=%b early=%b required 8/0/0", period, locked, early_err);
        end
        pulse(10);
        checks++;
        if (period !== 5'd10 || locked !== 1'b0 || late_err !== 1'b0) begin
            errors++;
            $display("FAIL win_10: period=%0d locked=%b late=%b required 10/0/0", period, locked, late_err);
        end
        pulse(9);
        checks++;
        if (period !== 5'd9 || locked !== 1'b1) begin
            errors++;
            $display("FAIL win_lock: period=%0d locked=%b required 9/1", period, locked);
        end
        pulse(8);
        pulse(10);
        checks++;
        if (period !== 5'd10 || locked !== 1'b1 || err_cnt !== 2'd2) begin
            errors++;
            $display("FAIL win_locked: period=%0d locked=%b err_cnt=%0d required 10/1/2",
                     period, locked, err_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [ECNT_W-1:0] exp_cnt;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        checks++;
        if (err_cnt !== 2'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_alone: err_cnt=%0d locked=%b required 0/1", err_cnt, locked);
        end
        pulse(5);
        checks++;
        if (err_cnt !== 2'd1 || early_err !== 1'b1 || locked !== 1'b0 || period !== 5'd5) begin
            errors++;
            $display("FAIL sat_1: err_cnt=%0d early=%b locked=%b period=%0d required 1/1/0/5",
                     err_cnt, early_err, locked, period);
        end
        // Back-to-back high cycles: each extra one is a spacing-1 early pulse.
        for (int i = 2; i <= 5; i++) begin
            pulse(1);
            exp_cnt = (i < 3) ? ECNT_W'(i) : 2'd3;
            checks++;
            if (err_cnt !== exp_cnt || early_err !== 1'b1 || period !== 5'd1) begin
                errors++;
                $display("FAIL sat_%0d: err_cnt=%0d early=%b period=%0d required %0d/1/1",
                         i, err_cnt, early_err, period, exp_cnt);
            end
        end
        idle(10 - cur_cnt);
        err_clr = 1'b1;
        idle(1);
        checks++;
        if (late_err !== 1'b1 || err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL clr_with_late: late=%b err_cnt=%0d required 1/1", late_err, err_cnt);
        end
        idle(1);
        err_clr = 1'b0;
        checks++;
        if (late_err !== 1'b0 || err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clr_after_late: late=%b err_cnt=%0d required 0/0", late_err, err_cnt);
        end
    endtask

    task automatic test_async_reset();
        sync_pulse();
        pulse(9);
        pulse(3);
        pulse(9);
        pulse(9);
        pulse(9);
        checks++;
        if (locked !== 1'b1 || err_cnt !== 2'd1 || period !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset: locked=%b err_cnt=%0d period=%0d required 1/1/9", locked, err_cnt, period);
        end
        idle(8 - cur_cnt);
        checks++;
        if (in_window !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_win: win=%b required 1", in_window);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, in_window, early_err, late_err, period, err_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: l=%b w=%b e=%b t=%b p=%0d c=%0d required all 0",
                     locked, in_window, early_err, late_err, period, err_cnt);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cur_cnt = 1;
        idle(2);
        sync_pulse();
        pulse(9);
        pulse(9);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_p3: locked=%b required 0", locked);
        end
        pulse(9);
        checks++;
        if (locked !== 1'b1 || period !== 5'd9 || err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL relock_p4: locked=%b period=%0d err_cnt=%0d required 1/9/0", locked, period, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_early();
        test_late();
        test_window();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
